// File: rtl/assoc_cache_if.sv
// CPU-side and memory-side handshake bundle for assoc_cache.
// The cache uses the slave view; the driving environment uses the master view.
interface assoc_cache_if #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
);
  logic               req;
  logic               rw;
  logic               flush;
  logic [A_WIDTH-1:0] addr;
  logic [D_WIDTH-1:0] wdata;
  logic               ready;
  logic               done;
  logic               hit;
  logic [D_WIDTH-1:0] rdata;
  logic               mem_req;
  logic               mem_rw;
  logic [A_WIDTH-1:0] mem_addr;
  logic [D_WIDTH-1:0] mem_wdata;
  logic [D_WIDTH-1:0] mem_rdata;
  logic               mem_ack;
  logic [15:0]        hit_cnt;
  logic [15:0]        miss_cnt;

  modport slave (
    input  req, rw, flush, addr, wdata, mem_rdata, mem_ack,
    output ready, done, hit, rdata, mem_req, mem_rw, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );

  modport master (
    output req, rw, flush, addr, wdata, mem_rdata, mem_ack,
    input  ready, done, hit, rdata, mem_req, mem_rw, mem_addr, mem_wdata,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/assoc_cache.sv
// Fully associative write-back / write-allocate cache with true-LRU ages,
// req/done handshakes on both CPU and memory sides, flush and hit/miss counters.
module assoc_cache #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int N       = 4,
  parameter int AGE_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             clr,
  assoc_cache_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_INSTALL,
    S_FLUSH,
    S_RESP
  } state_t;

  state_t             state;

  logic [N-1:0]       valid;
  logic [N-1:0]       dirty;
  logic [A_WIDTH-1:0] tag  [N];
  logic [D_WIDTH-1:0] data [N];
  logic [AGE_W-1:0]   age  [N];

  logic [A_WIDTH-1:0] cap_addr;
  logic               cap_rw;
  logic [D_WIDTH-1:0] cap_wdata;
  logic               op_flush;
  logic [AGE_W-1:0]   vic;
  logic [AGE_W-1:0]   fidx;

  logic               ready_q;
  logic               done_q;
  logic               hit_q;
  logic [D_WIDTH-1:0] rdata_q;
  logic               mem_req_q;
  logic               mem_rw_q;
  logic [A_WIDTH-1:0] mem_addr_q;
  logic [D_WIDTH-1:0] mem_wdata_q;
  logic [15:0]        hit_cnt_q;
  logic [15:0]        miss_cnt_q;

  logic               lk_hit;
  logic [AGE_W-1:0]   lk_way;
  logic [AGE_W-1:0]   lk_vic;
  logic               lk_found;
  logic               touch_en;
  logic [AGE_W-1:0]   touch_way;

  // Tag match requires valid, so a reset line (tag 0) never hits address 0.
  always_comb begin
    lk_hit   = 1'b0;
    lk_way   = '0;
    lk_vic   = '0;
    lk_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (valid[i] && (tag[i] == cap_addr)) begin
        lk_hit = 1'b1;
        lk_way = AGE_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid[i] && !lk_found) begin
        lk_vic   = AGE_W'(i);
        lk_found = 1'b1;
      end
    end
    if (!lk_found) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (age[i] == '0) lk_vic = AGE_W'(i);
      end
    end
  end

  always_comb begin
    touch_en  = ((state == S_LOOKUP) && lk_hit) || (state == S_INSTALL);
    touch_way = (state == S_INSTALL) ? vic : lk_way;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= S_IDLE;
      valid       <= '0;
      dirty       <= '0;
      cap_addr    <= '0;
      cap_rw      <= 1'b0;
      cap_wdata   <= '0;
      op_flush    <= 1'b0;
      vic         <= '0;
      fidx        <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
        age[i]  <= AGE_W'(i);
      end
    end else begin
      done_q <= 1'b0;

      // Ages stay a permutation: ways younger than the touched one shift down.
      if (touch_en) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (AGE_W'(i) == touch_way)       age[i] <= AGE_W'(N - 1);
          else if (age[i] > age[touch_way]) age[i] <= age[i] - AGE_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.flush) begin
            op_flush <= 1'b1;
            fidx     <= '0;
            ready_q  <= 1'b0;
            state    <= S_FLUSH;
          end else if (bus.req) begin
            op_flush  <= 1'b0;
            cap_addr  <= bus.addr;
            cap_rw    <= bus.rw;
            cap_wdata <= bus.wdata;
            ready_q   <= 1'b0;
            state     <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          hit_q <= lk_hit;
          if (lk_hit) begin
            if (cap_rw) begin
              data[lk_way]  <= cap_wdata;
              dirty[lk_way] <= 1'b1;
            end else begin
              rdata_q <= data[lk_way];
            end
            done_q <= 1'b1;
            state  <= S_RESP;
          end else begin
            vic <= lk_vic;
            if (valid[lk_vic] && dirty[lk_vic]) state <= S_WB;
            else if (cap_rw)                    state <= S_INSTALL;
            else                                state <= S_FILL;
          end
        end

        S_WB: begin
          if (!mem_req_q) begin
            mem_req_q   <= 1'b1;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= tag[vic];
            mem_wdata_q <= data[vic];
          end else if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            dirty[vic] <= 1'b0;
            state      <= cap_rw ? S_INSTALL : S_FILL;
          end
        end

        S_FILL: begin
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= cap_addr;
          end else if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            data[vic]  <= bus.mem_rdata;
            rdata_q    <= bus.mem_rdata;
            valid[vic] <= 1'b1;
            dirty[vic] <= 1'b0;
            state      <= S_INSTALL;
          end
        end

        S_INSTALL: begin
          tag[vic]   <= cap_addr;
          valid[vic] <= 1'b1;
          if (cap_rw) begin
            data[vic]  <= cap_wdata;
            dirty[vic] <= 1'b1;
          end
          done_q <= 1'b1;
          state  <= S_RESP;
        end

        // One way per cycle; a dirty way holds the index until its write is acked.
        S_FLUSH: begin
          if (mem_req_q) begin
            if (bus.mem_ack) begin
              mem_req_q   <= 1'b0;
              dirty[fidx] <= 1'b0;
              if (fidx == AGE_W'(N - 1)) begin
                done_q <= 1'b1;
                state  <= S_RESP;
              end else begin
                fidx <= fidx + AGE_W'(1);
              end
            end
          end else if (valid[fidx] && dirty[fidx]) begin
            mem_req_q   <= 1'b1;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= tag[fidx];
            mem_wdata_q <= data[fidx];
          end else if (fidx == AGE_W'(N - 1)) begin
            done_q <= 1'b1;
            state  <= S_RESP;
          end else begin
            fidx <= fidx + AGE_W'(1);
          end
        end

        S_RESP: begin
          if (!op_flush) begin
            if (hit_q) hit_cnt_q  <= hit_cnt_q + 16'd1;
            else       miss_cnt_q <= miss_cnt_q + 16'd1;
          end
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed scenarios then random traffic, compared against
// an LRU-list cache model and a random-latency memory responder.
module tb_assoc_cache;
  localparam int N = 4;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  assoc_cache_if #(.D_WIDTH(8), .A_WIDTH(8)) bus ();

  assoc_cache #(.D_WIDTH(8), .A_WIDTH(8), .N(N)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [7:0] a;
    logic [7:0] d;
  } mtx_t;

  mtx_t       exp_tx[$];
  mtx_t       got_tx[$];
  logic [7:0] tb_mem  [256];
  logic [7:0] ref_mem [256];
  bit         mem_hold;

  // Reference model: per-way contents plus a recency list (front = least recent).
  bit         m_valid [N];
  bit         m_dirty [N];
  logic [7:0] m_tag   [N];
  logic [7:0] m_data  [N];
  int         lru[$];
  int         m_hits;
  int         m_misses;
  logic [7:0] m_rdata;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    lru.delete();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      lru.push_back(i);
    end
    m_hits   = 0;
    m_misses = 0;
    m_rdata  = 8'h00;
  endtask

  task automatic touch(input int w);
    for (int i = 0; i < lru.size(); i++) begin
      if (lru[i] == w) begin
        lru.delete(i);
        break;
      end
    end
    lru.push_back(w);
  endtask

  task automatic model_access(input bit rw, input logic [7:0] a, input logic [7:0] d,
                              output bit is_hit, output int ntx);
    int w;
    w      = -1;
    ntx    = 0;
    for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == a) w = i;
    is_hit = (w >= 0);
    if (is_hit) begin
      m_hits++;
      if (rw) begin
        m_data[w]  = d;
        m_dirty[w] = 1;
      end else begin
        m_rdata = m_data[w];
      end
    end else begin
      m_misses++;
      for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) w = i;
      if (w < 0) w = lru[0];
      if (m_valid[w] && m_dirty[w]) begin
        exp_tx.push_back('{rw: 1'b1, a: m_tag[w], d: m_data[w]});
        ref_mem[m_tag[w]] = m_data[w];
        ntx++;
      end
      if (rw) begin
        m_data[w]  = d;
        m_dirty[w] = 1;
      end else begin
        exp_tx.push_back('{rw: 1'b0, a: a, d: ref_mem[a]});
        ntx++;
        m_data[w]  = ref_mem[a];
        m_dirty[w] = 0;
        m_rdata    = ref_mem[a];
      end
      m_valid[w] = 1;
      m_tag[w]   = a;
    end
    touch(w);
  endtask

  task automatic model_flush(output int ntx);
    ntx = 0;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        exp_tx.push_back('{rw: 1'b1, a: m_tag[i], d: m_data[i]});
        ref_mem[m_tag[i]] = m_data[i];
        m_dirty[i] = 0;
        ntx++;
      end
    end
  endtask

  // Memory responder: random ack latency, aborts silently if mem_req drops.
  initial begin
    logic [7:0] a0;
    bit         alive;
    int         l;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !bus.mem_ack) begin
        a0    = bus.mem_addr;
        alive = 1;
        l     = int'($urandom_range(0, 3));
        while (alive && (mem_hold || l > 0)) begin
          @(negedge clk);
          if (!bus.mem_req) alive = 0;
          if (l > 0) l--;
        end
        if (alive) begin
          check("mem_addr_stable", 32'(bus.mem_addr), 32'(a0));
          if (bus.mem_rw) begin
            tb_mem[bus.mem_addr] = bus.mem_wdata;
            got_tx.push_back('{rw: 1'b1, a: bus.mem_addr, d: bus.mem_wdata});
          end else begin
            bus.mem_rdata = tb_mem[bus.mem_addr];
            got_tx.push_back('{rw: 1'b0, a: bus.mem_addr, d: tb_mem[bus.mem_addr]});
          end
          bus.mem_ack = 1'b1;
          @(negedge clk);
          bus.mem_ack = 1'b0;
        end
      end
    end
  end

  task automatic do_op(input bit fl, input bit rw, input logic [7:0] a, input logic [7:0] d,
                       output int lat);
    int guard;
    guard = 0;
    while (!bus.ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 32'(guard < 200), 32'd1);
    bus.req   = !fl;
    bus.flush = fl;
    bus.rw    = rw;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    bus.req   = 1'b0;
    bus.flush = 1'b0;
    lat       = 1;
    while (!bus.done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(lat < 300), 32'd1);
  endtask

  task automatic compare_tx();
    check("mem_tx_count", 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++) begin
      check("mem_tx_rw", 32'(got_tx[i].rw), 32'(exp_tx[i].rw));
      check("mem_tx_addr", 32'(got_tx[i].a), 32'(exp_tx[i].a));
      check("mem_tx_data", 32'(got_tx[i].d), 32'(exp_tx[i].d));
    end
    got_tx.delete();
    exp_tx.delete();
  endtask

  task automatic run_op(input bit fl, input bit rw, input logic [7:0] a, input logic [7:0] d);
    int lat;
    int ntx;
    bit eh;
    eh = 0;
    do_op(fl, rw, a, d, lat);
    if (fl) model_flush(ntx);
    else    model_access(rw, a, d, eh, ntx);
    if (!fl) check("hit", 32'(bus.hit), 32'(eh));
    check("rdata", 32'(bus.rdata), 32'(m_rdata));
    if (fl && ntx == 0)         check("clean_flush_latency", 32'(lat), 32'(N + 1));
    if (!fl && eh)              check("hit_latency", 32'(lat), 32'd2);
    if (!fl && !eh && rw && ntx == 0) check("clean_wmiss_latency", 32'(lat), 32'd3);
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("ready_back", 32'(bus.ready), 32'd1);
    check("mem_req_idle", 32'(bus.mem_req), 32'd0);
    check("hit_cnt", 32'(bus.hit_cnt), 32'(m_hits));
    check("miss_cnt", 32'(bus.miss_cnt), 32'(m_misses));
    compare_tx();
  endtask

  initial begin
    int   guard;
    logic [7:0] ra;
    checks    = 0;
    errors    = 0;
    mem_hold  = 0;
    clr       = 1'b0;
    bus.req   = 1'b0;
    bus.flush = 1'b0;
    bus.rw    = 1'b0;
    bus.addr  = 8'h00;
    bus.wdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[8'h00] = 8'h3C; ref_mem[8'h00] = 8'h3C;
    tb_mem[8'h10] = 8'hA1; ref_mem[8'h10] = 8'hA1;
    tb_mem[8'h20] = 8'hA2; ref_mem[8'h20] = 8'hA2;
    tb_mem[8'h30] = 8'hA3; ref_mem[8'h30] = 8'hA3;
    tb_mem[8'h40] = 8'hA4; ref_mem[8'h40] = 8'hA4;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hit", 32'(bus.hit), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // Directed sequence.
    run_op(0, 0, 8'h00, 8'h00);
    check("first_read_data", 32'(bus.rdata), 32'h3C);
    run_op(0, 0, 8'h10, 8'h00);
    run_op(0, 0, 8'h20, 8'h00);
    run_op(0, 0, 8'h30, 8'h00);
    run_op(0, 0, 8'h40, 8'h00);
    run_op(0, 0, 8'h20, 8'h00);
    check("reread_hit", 32'(bus.hit), 32'd1);
    check("reread_data", 32'(bus.rdata), 32'hA2);
    run_op(0, 0, 8'h50, 8'h00);
    run_op(0, 1, 8'h30, 8'h5C);
    run_op(0, 0, 8'h40, 8'h00);
    run_op(0, 0, 8'h20, 8'h00);
    run_op(0, 0, 8'h50, 8'h00);
    run_op(0, 0, 8'h60, 8'h00);
    check("wb_then_fill_mem", 32'(tb_mem[8'h30]), 32'h5C);
    run_op(0, 1, 8'h40, 8'h77);
    run_op(0, 1, 8'h20, 8'h88);
    run_op(1, 0, 8'h00, 8'h00);
    run_op(1, 0, 8'h00, 8'h00);

    // Reset while a fill is outstanding.
    mem_hold  = 1;
    bus.req   = 1'b1;
    bus.rw    = 1'b0;
    bus.addr  = 8'hF0;
    @(negedge clk);
    bus.req = 1'b0;
    guard   = 0;
    while (!bus.mem_req && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("fill_req_seen", 32'(bus.mem_req), 32'd1);
    clr = 1'b0;
    #1;
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    @(negedge clk);
    clr      = 1'b1;
    mem_hold = 0;
    model_reset();
    got_tx.delete();
    exp_tx.delete();
    @(negedge clk);
    run_op(0, 0, 8'h20, 8'h00);
    check("post_reset_miss", 32'(bus.hit), 32'd0);

    // Random traffic over a small address set to force hits and evictions.
    for (int k = 0; k < 150; k++) begin
      ra = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) run_op(1, 0, 8'h00, 8'h00);
      else run_op(0, 1'($urandom_range(0, 1)), ra, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
